// File: rtl/mc_control_if.sv
// Control bundle between the multicycle controller and the MIPS datapath.
// master = controller (drives selects/strobes), slave = datapath side.
interface mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond_eq;
  logic       pc_write_cond_ne;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] aluop;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  // Handshake: a memory access is requested by holding mem_read or mem_write
  // high; it completes in the cycle mem_ready=1 and the strobe may then drop.
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond_eq, pc_write_cond_ne, pc_source, iord,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, aluop, instr_done, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond_eq, pc_write_cond_ne, pc_source, iord,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, aluop, instr_done, illegal, state
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory and
// writeback for LW/SW/ADDI/BEQ/BNE/ADD/J with a memory-ready stall handshake.
package AluCtrlSig_pkg;
  parameter logic [5:0] LW_op   = 6'b100011;
  parameter logic [5:0] SW_op   = 6'b101011;
  parameter logic [5:0] ADDI_op = 6'b001000;
  parameter logic [5:0] BEQ_op  = 6'b000100;
  parameter logic [5:0] BNE_op  = 6'b000101;
  parameter logic [5:0] ADD_op  = 6'b000000;
  parameter logic [5:0] J_op    = 6'b000010;
endpackage

module mc_control
  import AluCtrlSig_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mc_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  state_e state_q;
  logic   illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:     if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            LW_op, SW_op:   state_q <= S_MEM_ADDR;
            ADD_op:         state_q <= S_R_EXEC;
            ADDI_op:        state_q <= S_ADDI_EXEC;
            BEQ_op, BNE_op: state_q <= S_BRANCH;
            J_op:           state_q <= S_JUMP;
            default: begin
              state_q   <= S_TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR:  state_q <= (bus.opcode == LW_op) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (bus.mem_ready) state_q <= S_MEM_WB;
        S_MEM_WB:    state_q <= S_FETCH;
        S_MEM_WRITE: if (bus.mem_ready) state_q <= S_FETCH;
        S_R_EXEC:    state_q <= S_R_WB;
        S_R_WB:      state_q <= S_FETCH;
        S_BRANCH:    state_q <= S_FETCH;
        S_JUMP:      state_q <= S_FETCH;
        S_ADDI_EXEC: state_q <= S_ADDI_WB;
        S_ADDI_WB:   state_q <= S_FETCH;
        S_TRAP:      state_q <= S_TRAP;
        default: begin
          state_q   <= S_TRAP;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  logic       pc_write_s, cond_eq_s, cond_ne_s, mem_read_s, mem_write_s;
  logic       ir_write_s, reg_write_s, instr_done_s;
  logic       iord_s, reg_dst_s, mem_to_reg_s, alu_src_a_s;
  logic [1:0] pc_source_s, alu_src_b_s, aluop_s;

  // Selects default to their FETCH values; strobes default off.
  always_comb begin
    pc_write_s   = 1'b0;
    cond_eq_s    = 1'b0;
    cond_ne_s    = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    instr_done_s = 1'b0;
    iord_s       = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b01;
    aluop_s      = 2'b00;
    pc_source_s  = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        ir_write_s = bus.mem_ready;
        pc_write_s = bus.mem_ready;
      end
      S_DECODE:    alu_src_b_s = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_s  = 1'b1;
        iord_s       = 1'b1;
        instr_done_s = bus.mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b00;
        aluop_s     = 2'b10;
      end
      S_R_WB: begin
        reg_dst_s    = 1'b1;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b00;
        aluop_s      = 2'b01;
        pc_source_s  = 2'b01;
        cond_eq_s    = (bus.opcode == BEQ_op);
        cond_ne_s    = (bus.opcode == BNE_op);
        instr_done_s = 1'b1;
      end
      S_JUMP: begin
        pc_write_s   = 1'b1;
        pc_source_s  = 2'b10;
        instr_done_s = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Gating with rst_n kills every write the instant reset falls, even mid-cycle.
  assign bus.pc_write         = pc_write_s   & rst_n;
  assign bus.pc_write_cond_eq = cond_eq_s    & rst_n;
  assign bus.pc_write_cond_ne = cond_ne_s    & rst_n;
  assign bus.mem_read         = mem_read_s   & rst_n;
  assign bus.mem_write        = mem_write_s  & rst_n;
  assign bus.ir_write         = ir_write_s   & rst_n;
  assign bus.reg_write        = reg_write_s  & rst_n;
  assign bus.instr_done       = instr_done_s & rst_n;
  assign bus.iord             = iord_s;
  assign bus.reg_dst          = reg_dst_s;
  assign bus.mem_to_reg       = mem_to_reg_s;
  assign bus.alu_src_a        = alu_src_a_s;
  assign bus.alu_src_b        = alu_src_b_s;
  assign bus.aluop            = aluop_s;
  assign bus.pc_source        = pc_source_s;
  assign bus.illegal          = illegal_q;
  assign bus.state            = state_q;

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control FSM for the MIPS datapath. It sequences the shared ALU, unified memory port, IR/MDR and register file over several clock cycles per instruction, for the opcodes the single-cycle decoder supports: LW, SW, ADDI, BEQ, BNE, R-type ADD, J. It sits beside the datapath, reads `opcode` from the IR, and drives every mux select and write strobe. A memory-ready handshake lets instruction fetch and data accesses stall.

## Interface

Parameters: none (opcode encodings come from `AluCtrlSig_pkg`: LW_op, SW_op, ADDI_op, BEQ_op, BNE_op, ADD_op, J_op).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; stable from DECODE until the instruction completes.
- `mem_ready`  in  1  memory access completes this cycle; sampled only in FETCH, MEM_READ and MEM_WRITE.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond_eq`, `pc_write_cond_ne`  out  1 each  PC load qualified by ALU zero / !zero.
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `ir_write`  out  1  IR load.
- `reg_dst`  out  1  write register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  0 = PC, 1 = A.
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `aluop`  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction.
- `illegal`  out  1  sticky; set on an unsupported opcode.
- `state`  out  4  current state encoding, for debug.

## Operation

States and encodings, with outputs. Unlisted outputs are 0; unlisted selects take the FETCH values.
- FETCH (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=00; ir_write = pc_write = mem_ready. Stays in FETCH while !mem_ready; otherwise goes to DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=11, aluop=00. Next state by opcode:
  - LW/SW → MEM_ADDR
  - ADD → R_EXEC
  - ADDI → ADDI_EXEC
  - BEQ/BNE → BRANCH
  - J → JUMP
  - any other opcode → TRAP
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, aluop=00. Goes to MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ (3): mem_read=1, iord=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB (4): reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Goes to FETCH.
- MEM_WRITE (5): mem_write=1, iord=1. Waits for mem_ready; instr_done = mem_ready; then goes to FETCH.
- R_EXEC (6): alu_src_a=1, alu_src_b=00, aluop=10. Goes to R_WB.
- R_WB (7): reg_dst=1, reg_write=1, instr_done=1. Goes to FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, aluop=01, pc_source=01; pc_write_cond_eq=(opcode==BEQ_op), pc_write_cond_ne=(opcode==BNE_op); instr_done=1. Goes to FETCH.
- JUMP (9): pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- ADDI_EXEC (10): alu_src_a=1, alu_src_b=10, aluop=00. Goes to ADDI_WB.
- ADDI_WB (11): reg_dst=0, reg_write=1, instr_done=1. Goes to FETCH.
- TRAP (12): illegal=1 and every strobe is 0. TRAP is absorbing; only reset leaves it.
- Encodings 13–15 are unreachable; if entered, the next state is TRAP.

## Timing

- Reset (rst_n=0):
  - State goes to FETCH asynchronously; `illegal` clears.
  - All strobes are forced to 0 combinationally by rst_n: pc_write, pc_write_cond_*, ir_write, mem_read, mem_write, reg_write, instr_done.
  - Selects hold their FETCH values; `state`=0.
- Reset asserted mid-instruction aborts it immediately. No partial write is issued after the rst_n falling edge.
- The first FETCH access starts in the first cycle after rst_n rises.
- Latency with mem_ready held at 1: LW 5 cycles, SW 4, ADD 4, ADDI 4, BEQ/BNE 3, J 3.
- Each cycle mem_ready is low in a waiting state adds one cycle.
- mem_ready is ignored in all other states.
- Strobes are Moore outputs, except ir_write, pc_write (FETCH) and instr_done (MEM_WRITE), which are Mealy on mem_ready.
- A memory strobe stays asserted continuously until the cycle in which mem_ready=1.

## Test plan

- LW, mem_ready=1: state sequence 0,1,2,3,4,0. mem_read=1 in cycles 1 and 4; reg_write=1, mem_to_reg=1 and instr_done=1 only in cycle 5.
- FETCH with mem_ready low for 3 cycles, then high: state stays 0 for 4 cycles. ir_write and pc_write are 1 only in the 4th cycle. Next state is 1.
- BEQ then BNE: each takes 3 cycles. In BRANCH, aluop=01 and pc_source=01; cond_eq=1/cond_ne=0 for BEQ and the reverse for BNE. reg_write is never 1.
- SW with mem_ready low for 2 cycles in MEM_WRITE: mem_write=1 for 3 consecutive cycles. instr_done pulses on the 3rd. reg_write stays 0.
- opcode=6'b111111: state goes to 12 after DECODE, illegal=1 and stays 1 for 10+ cycles with no strobes. A rst_n pulse returns the block to state 0 with illegal=0.
- rst_n dropped mid-MEM_WRITE (async, between edges): mem_write falls to 0 immediately and state=0. After release, J executes with pc_write=1, pc_source=10 and instr_done=1 in its 3rd cycle.
